// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT control and the IF/ID pipeline register.
// imem_addr is the live PC; every other output comes straight from a flop.
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INST  = 32'h00000013,
    parameter logic [31:0] HALT_INST = 32'h00000073
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [63:0] ifid_pc,
    output logic [63:0] ifid_pc4,
    output logic [31:0] ifid_inst,
    output logic        ifid_valid,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   redirect_aligned;
    logic [XLEN-1:0]   pc_nxt;
    logic              take_redirect;
    logic              load_bubble;
    logic              load_fetch;
    logic              fetch_is_halt;

    assign imem_addr        = pc;
    assign pc_plus4         = pc + XLEN'(4);
    assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
    assign take_redirect    = redirect_valid && (state != S_BOOT);
    assign fetch_is_halt    = (imem_data == HALT_INST);

    // Decide next PC and what the IF/ID register captures this cycle.
    always_comb begin
        pc_nxt      = pc;
        load_bubble = 1'b0;
        load_fetch  = 1'b0;
        case (state)
            S_BOOT: begin
                load_bubble = 1'b1;
            end
            S_RUN: begin
                if (take_redirect) begin
                    pc_nxt      = redirect_aligned;
                    load_bubble = 1'b1;
                end else if (flush) begin
                    load_bubble = 1'b1;
                    if (!stall) begin
                        pc_nxt = pc_plus4;
                    end
                end else if (!stall) begin
                    load_fetch = 1'b1;
                    // A halt freezes the PC on its own address.
                    pc_nxt     = fetch_is_halt ? pc : pc_plus4;
                end
            end
            S_HALT: begin
                load_bubble = 1'b1;
                if (take_redirect) begin
                    pc_nxt = redirect_aligned;
                end
            end
            default: begin
                load_bubble = 1'b1;
            end
        endcase
    end

    // State, PC and IF/ID register; stall with no redirect/flush simply holds everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_BOOT;
            pc           <= RESET_PC;
            ifid_pc      <= '0;
            ifid_pc4     <= '0;
            ifid_inst    <= NOP_INST;
            ifid_valid   <= 1'b0;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else begin
            pc <= pc_nxt;

            if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                misalign_err <= 1'b1;
            end

            if (load_bubble) begin
                ifid_pc    <= '0;
                ifid_pc4   <= '0;
                ifid_inst  <= NOP_INST;
                ifid_valid <= 1'b0;
            end else if (load_fetch) begin
                ifid_pc    <= pc;
                ifid_pc4   <= pc_plus4;
                ifid_inst  <= imem_data;
                ifid_valid <= 1'b1;
                if (fetch_count != {ILEN{1'b1}}) begin
                    fetch_count <= fetch_count + ILEN'(1);
                end
            end

            case (state)
                S_BOOT: begin
                    state  <= S_RUN;
                    halted <= 1'b0;
                end
                S_RUN: begin
                    if (load_fetch && fetch_is_halt) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (take_redirect) begin
                        state  <= S_RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_BOOT;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, stall, flush, halt, redirects, misalign, async reset and PC wrap.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic [63:0] ifid_pc;
    logic [63:0] ifid_pc4;
    logic [31:0] ifid_inst;
    logic        ifid_valid;
    logic        halted;
    logic        misalign_err;
    logic [31:0] fetch_count;

    // Second instance starting at the top of the address space to exercise PC wrap.
    logic        quiet_stall;
    logic        quiet_flush;
    logic        quiet_redirect;
    logic [63:0] quiet_redirect_pc;
    logic [63:0] w_imem_addr;
    logic [31:0] w_imem_data;
    logic [63:0] w_ifid_pc;
    logic [63:0] w_ifid_pc4;
    logic [31:0] w_ifid_inst;
    logic        w_ifid_valid;
    logic        w_halted;
    logic        w_misalign_err;
    logic [31:0] w_fetch_count;

    logic [31:0] mem [0:63];

    int checks_total  = 0;
    int checks_passed = 0;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] HALT = 32'h00000073;
    localparam logic [63:0] TOP  = 64'hFFFF_FFFF_FFFF_FFFC;

    always #5 clk = ~clk;

    assign imem_data   = mem[imem_addr[7:2]];
    assign w_imem_data = mem[w_imem_addr[7:2]];

    fetch_stage u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4), .ifid_inst(ifid_inst),
        .ifid_valid(ifid_valid), .halted(halted), .misalign_err(misalign_err),
        .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(TOP)) u_wrap (
        .clk(clk), .rst(rst), .stall(quiet_stall), .flush(quiet_flush),
        .redirect_valid(quiet_redirect), .redirect_pc(quiet_redirect_pc),
        .imem_addr(w_imem_addr), .imem_data(w_imem_data),
        .ifid_pc(w_ifid_pc), .ifid_pc4(w_ifid_pc4), .ifid_inst(w_ifid_inst),
        .ifid_valid(w_ifid_valid), .halted(w_halted), .misalign_err(w_misalign_err),
        .fetch_count(w_fetch_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = NOP;
        mem[0]  = 32'h00500093;
        mem[1]  = 32'h00100113;
        mem[2]  = 32'h00200193;
        mem[3]  = 32'h00300213;
        mem[4]  = HALT;
        mem[16] = 32'h00a00513;

        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        quiet_stall = 1'b0; quiet_flush = 1'b0;
        quiet_redirect = 1'b0; quiet_redirect_pc = '0;

        #12;
        check("rst_addr",     imem_addr, 64'h0);
        check("rst_valid",    64'(ifid_valid), 64'h0);
        check("rst_inst",     64'(ifid_inst), 64'(NOP));
        check("rst_halted",   64'(halted), 64'h0);
        check("rst_count",    64'(fetch_count), 64'h0);
        check("rst_misalign", 64'(misalign_err), 64'h0);
        check("rst_wrap_addr", w_imem_addr, TOP);

        @(negedge clk);
        rst = 1'b1;

        // Boot: first edge is a bubble, second edge latches the word at RESET_PC.
        step();
        check("boot1_valid", 64'(ifid_valid), 64'h0);
        check("boot1_addr",  imem_addr, 64'h0);
        check("boot1_wrap_addr", w_imem_addr, TOP);
        step();
        check("boot2_pc",    ifid_pc, 64'h0);
        check("boot2_pc4",   ifid_pc4, 64'h4);
        check("boot2_inst",  64'(ifid_inst), 64'h00500093);
        check("boot2_valid", 64'(ifid_valid), 64'h1);
        check("boot2_addr",  imem_addr, 64'h4);
        check("boot2_count", 64'(fetch_count), 64'h1);
        check("wrap_pc",     w_ifid_pc, TOP);
        check("wrap_pc4",    w_ifid_pc4, 64'h0);
        check("wrap_addr",   w_imem_addr, 64'h0);
        check("wrap_inst",   64'(w_ifid_inst), 64'(NOP));
        check("wrap_valid",  64'(w_ifid_valid), 64'h1);
        check("wrap_count",  64'(w_fetch_count), 64'h1);
        check("wrap_halted", 64'(w_halted), 64'h0);
        check("wrap_misalign", 64'(w_misalign_err), 64'h0);
        step();
        check("run_pc",    ifid_pc, 64'h4);
        check("run_addr",  imem_addr, 64'h8);

        // Stall three cycles at PC=8.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr",  imem_addr, 64'h8);
            check("stall_pc",    ifid_pc, 64'h4);
            check("stall_inst",  64'(ifid_inst), 64'h00100113);
            check("stall_valid", 64'(ifid_valid), 64'h1);
            check("stall_count", 64'(fetch_count), 64'h2);
        end
        stall = 1'b0;
        step();
        check("unstall_pc",    ifid_pc, 64'h8);
        check("unstall_inst",  64'(ifid_inst), 64'h00200193);
        check("unstall_addr",  imem_addr, 64'hC);
        check("unstall_count", 64'(fetch_count), 64'h3);

        // Flush bubbles IF/ID while the PC still advances.
        flush = 1'b1;
        step();
        check("flush_valid", 64'(ifid_valid), 64'h0);
        check("flush_pc",    ifid_pc, 64'h0);
        check("flush_pc4",   ifid_pc4, 64'h0);
        check("flush_inst",  64'(ifid_inst), 64'(NOP));
        check("flush_addr",  imem_addr, 64'h10);
        check("flush_count", 64'(fetch_count), 64'h3);
        flush = 1'b0;

        // Halt at 0x10.
        step();
        check("halt_inst",   64'(ifid_inst), 64'(HALT));
        check("halt_valid",  64'(ifid_valid), 64'h1);
        check("halt_pc",     ifid_pc, 64'h10);
        check("halt_flag",   64'(halted), 64'h1);
        check("halt_addr",   imem_addr, 64'h10);
        check("halt_count",  64'(fetch_count), 64'h4);
        step();
        check("halted_valid", 64'(ifid_valid), 64'h0);
        check("halted_addr",  imem_addr, 64'h10);
        check("halted_flag",  64'(halted), 64'h1);
        check("halted_count", 64'(fetch_count), 64'h4);

        // Redirect out of HALT.
        redirect_valid = 1'b1; redirect_pc = 64'h0;
        step();
        check("resume_halted", 64'(halted), 64'h0);
        check("resume_valid",  64'(ifid_valid), 64'h0);
        check("resume_addr",   imem_addr, 64'h0);
        redirect_valid = 1'b0;
        step();
        check("resume_pc",    ifid_pc, 64'h0);
        check("resume_v",     64'(ifid_valid), 64'h1);
        check("resume_count", 64'(fetch_count), 64'h5);

        // Redirect wins over a simultaneous stall.
        redirect_valid = 1'b1; redirect_pc = 64'h40; stall = 1'b1;
        step();
        check("rdst_addr",  imem_addr, 64'h40);
        check("rdst_valid", 64'(ifid_valid), 64'h0);
        redirect_valid = 1'b0; stall = 1'b0;
        step();
        check("rdst_pc",    ifid_pc, 64'h40);
        check("rdst_inst",  64'(ifid_inst), 64'h00a00513);
        check("rdst_count", 64'(fetch_count), 64'h6);
        check("rdst_next",  imem_addr, 64'h44);
        check("rdst_noerr", 64'(misalign_err), 64'h0);

        // Misaligned redirect is aligned down and flagged stickily.
        redirect_valid = 1'b1; redirect_pc = 64'h43;
        step();
        check("mis_addr",  imem_addr, 64'h40);
        check("mis_err",   64'(misalign_err), 64'h1);
        check("mis_valid", 64'(ifid_valid), 64'h0);
        redirect_valid = 1'b0; redirect_pc = 64'h0;
        for (int i = 0; i < 2; i++) step();
        check("mis_sticky", 64'(misalign_err), 64'h1);
        check("mis_pc",     ifid_pc, 64'h44);

        // Async reset between edges, without a clock edge.
        #2;
        rst = 1'b0;
        #1;
        check("async_addr",     imem_addr, 64'h0);
        check("async_valid",    64'(ifid_valid), 64'h0);
        check("async_count",    64'(fetch_count), 64'h0);
        check("async_misalign", 64'(misalign_err), 64'h0);
        check("async_pc",       ifid_pc, 64'h0);
        check("async_wrap",     w_imem_addr, TOP);
        #1;
        rst = 1'b1;
        step();
        check("reboot1_valid", 64'(ifid_valid), 64'h0);
        step();
        check("reboot2_valid", 64'(ifid_valid), 64'h1);
        check("reboot2_inst",  64'(ifid_inst), 64'h00500093);
        check("reboot2_addr",  imem_addr, 64'h4);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
